vga_sync_to_count: RTL and testbench

- Receive-side counterpart of the VGA sync generator.
- Takes the HSync/VSync pair and regenerates aligned column/row counts, with frame-lock detection and a sync-error check.
- Used where a downstream pixel stage (porch blanking, overlay, capture) sees only sync signals, not the generator's counters.
- Sits between any sync source and VGA_Sync_Porch-style consumers.

---
 rtl/vga_sync_to_count_pkg.sv | 29 ++
 rtl/vga_lock_fsm.sv | 79 +++++++
 rtl/vga_sync_to_count.sv | 159 +++++++++++++++
 tb/tb_vga_sync_to_count.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_to_count_pkg.sv
// rtl/vga_sync_to_count_pkg.sv - shared timing constants, lock states and count helper for vga_sync_to_count
package vga_sync_to_count_pkg;

  // Count width is fixed; every timing below must fit in it.
  localparam int COUNT_W = 10;
  localparam int GOOD_W  = 4;

  // Default 640x480 timing, also used by the sync generator and porch stages.
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  // Increment with wrap to zero after the last legal value.
  function automatic logic [COUNT_W-1:0] wrap_inc(input logic [COUNT_W-1:0] value,
                                                  input logic [COUNT_W-1:0] last);
    return (value == last) ? '0 : value + COUNT_ONE;
  endfunction

endpackage

// File: rtl/vga_lock_fsm.sv
// rtl/vga_lock_fsm.sv - frame-lock state machine counting consecutive clean frames
module vga_lock_fsm
  import vga_sync_to_count_pkg::*;
#(
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VRise,
  input  logic i_Error,
  input  logic i_Frame_Good,
  output logic o_Tracking,
  output logic o_Locked_Nxt,
  output logic o_Locked
);

  // good holds the number of clean frames seen so far; reaching the last one locks.
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  lock_state_t       state;
  lock_state_t       state_nxt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_nxt;

  // Once the first VRise has been seen the parent's counts are meaningful.
  assign o_Tracking   = (state != ST_UNLOCKED);
  assign o_Locked_Nxt = (state_nxt == ST_LOCKED);

  // State, clean-frame count and registered lock flag.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= ST_UNLOCKED;
      good     <= '0;
      o_Locked <= 1'b0;
    end else begin
      state    <= state_nxt;
      good     <= good_nxt;
      o_Locked <= o_Locked_Nxt;
    end
  end

  // Next state: the acquiring frame never counts; any error restarts the tally.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      ST_UNLOCKED: begin
        if (i_VRise) begin
          state_nxt = ST_ACQUIRE;
          good_nxt  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (i_Error) begin
          good_nxt = '0;
        end else if (i_Frame_Good) begin
          if (good == LOCK_LAST) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good + GOOD_ONE;
          end
        end
      end
      ST_LOCKED: begin
        if (i_Error) begin
          state_nxt = ST_ACQUIRE;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_UNLOCKED;
        good_nxt  = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_sync_to_count.sv
// rtl/vga_sync_to_count.sv - regenerates column/row counts from HSync/VSync with lock and error detection (option: VGA_SYNC_TO_COUNT_ERR_CNT_EN)
module vga_sync_to_count
  import vga_sync_to_count_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_HSync,
  input  logic               i_VSync,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count,
  output logic               o_Locked,
  output logic               o_Active,
  output logic [7:0]         o_Err_Count
);

  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 ||
      ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS ||
      LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_param_check
    $error("vga_sync_to_count: unsupported timing parameters");
  end

  localparam logic [COUNT_W-1:0] LAST_COL = COUNT_W'(TOTAL_COLS - 1);
  localparam logic [COUNT_W-1:0] LAST_ROW = COUNT_W'(TOTAL_ROWS - 1);

  logic               sync_valid;
  logic               h_rise;
  logic               v_rise;
  logic               at_last_col;
  logic               at_frame_end;
  logic               line_err;
  logic               frame_err;
  logic               sync_err;
  logic               frame_clean;
  logic               frame_good;
  logic               tracking;
  logic               locked_nxt;
  logic [COUNT_W-1:0] col_nxt;
  logic [COUNT_W-1:0] row_nxt;

  // After reset the delayed syncs read 0 without having sampled anything, so
  // edges are ignored until one real sample is held; otherwise a reset released
  // mid-frame would see a fake VRise and lock onto the wrong position.
  assign h_rise = sync_valid & i_HSync & ~o_HSync;
  assign v_rise = sync_valid & i_VSync & ~o_VSync;

  assign at_last_col  = (o_Col_Count == LAST_COL);
  assign at_frame_end = at_last_col & (o_Row_Count == LAST_ROW);

  // HRise belongs exactly at the last column; a missing or early one is a line error.
  assign line_err  = at_last_col ^ h_rise;
  assign frame_err = v_rise & ~at_frame_end;

  // Line and frame faults in one cycle collapse into a single error.
  assign sync_err   = tracking & (line_err | frame_err);
  assign frame_good = v_rise & ~sync_err & frame_clean;

  // Delayed syncs that the counts describe, plus the sample-valid flag.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync    <= 1'b0;
      o_VSync    <= 1'b0;
      sync_valid <= 1'b0;
    end else begin
      o_HSync    <= i_HSync;
      o_VSync    <= i_VSync;
      sync_valid <= 1'b1;
    end
  end

  // Next count: VRise resyncs both, HRise resyncs the column, otherwise free-run.
  always_comb begin
    col_nxt = o_Col_Count;
    row_nxt = o_Row_Count;
    if (v_rise) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (tracking) begin
      if (h_rise) begin
        col_nxt = '0;
        row_nxt = wrap_inc(o_Row_Count, LAST_ROW);
      end else begin
        col_nxt = wrap_inc(o_Col_Count, LAST_COL);
        if (at_last_col) begin
          row_nxt = wrap_inc(o_Row_Count, LAST_ROW);
        end
      end
    end
  end

  // Count registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Col_Count <= '0;
      o_Row_Count <= '0;
    end else begin
      o_Col_Count <= col_nxt;
      o_Row_Count <= row_nxt;
    end
  end

  // A frame is clean if no error occurred between two VRises; each VRise opens a new frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      frame_clean <= 1'b0;
    end else if (v_rise) begin
      frame_clean <= 1'b1;
    end else if (sync_err) begin
      frame_clean <= 1'b0;
    end
  end

  vga_lock_fsm #(
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock_fsm (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_VRise      (v_rise),
    .i_Error      (sync_err),
    .i_Frame_Good (frame_good),
    .o_Tracking   (tracking),
    .o_Locked_Nxt (locked_nxt),
    .o_Locked     (o_Locked)
  );

  // Active flag registered alongside o_HSync/o_VSync/o_Locked so all four line up.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Active <= 1'b0;
    end else begin
      o_Active <= i_HSync & i_VSync & locked_nxt;
    end
  end

`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Saturating error tally, cleared only by reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      err_cnt <= 8'd0;
    end else if (sync_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_Err_Count = err_cnt;
`else
  assign o_Err_Count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_to_count.sv
// tb/tb_vga_sync_to_count.sv - self-checking bench for vga_sync_to_count on reduced 10x6 timing
module tb_vga_sync_to_count;

  localparam int TC = 10;
  localparam int TR = 6;
  localparam int AC = 8;
  localparam int AR = 4;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic       hs_out;
  logic       vs_out;
  logic [9:0] col;
  logic [9:0] row;
  logic       locked;
  logic       active;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  vga_sync_to_count #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .LOCK_FRAMES (LF)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_HSync     (hs_in),
    .i_VSync     (vs_in),
    .o_HSync     (hs_out),
    .o_VSync     (vs_out),
    .o_Col_Count (col),
    .o_Row_Count (row),
    .o_Locked    (locked),
    .o_Active    (active),
    .o_Err_Count (err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Sync source: position plus per-line faults (shortened line, HSync held low).
  int gcol = 0;
  int grow = 0;
  bit short_line = 0;
  bit hold_line = 0;
  bit inj_short = 0;
  bit inj_hold = 0;
  bit rand_mode = 0;
  bit storm = 0;

  // Reference model: linear pixel position within the frame, clean-frame streak.
  bit m_valid, m_acq, m_dirty, m_hs, m_vs, m_locked, m_active;
  int m_pos, m_streak, m_errs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_acq = 0; m_dirty = 0; m_hs = 0; m_vs = 0;
    m_locked = 0; m_active = 0; m_pos = 0; m_streak = 0; m_errs = 0;
  endtask

  task automatic check_outputs();
    int exp_err;
`ifdef VGA_SYNC_TO_COUNT_ERR_CNT_EN
    exp_err = (m_errs > 255) ? 255 : m_errs;
`else
    exp_err = 0;
`endif
    check("hsync", 32'(hs_out), 32'(m_hs));
    check("vsync", 32'(vs_out), 32'(m_vs));
    check("col", 32'(col), 32'(m_pos % TC));
    check("row", 32'(row), 32'(m_pos / TC));
    check("locked", 32'(locked), 32'(m_locked));
    check("active", 32'(active), 32'(m_active));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hr, vr, err, good;
    hr = m_valid && hs && !m_hs;
    vr = m_valid && vs && !m_vs;
    err = m_acq && ((((m_pos % TC) == TC - 1) != hr) || (vr && (m_pos != TC * TR - 1)));
    good = vr && m_acq && !err && !m_dirty;
    if (err) begin
      m_errs++;
      m_streak = 0;
      m_dirty = 1;
    end
    if (good) m_streak++;
    if (vr) begin
      m_acq = 1;
      m_dirty = 0;
      m_pos = 0;
    end else if (m_acq) begin
      if (hr) m_pos = ((m_pos / TC + 1) % TR) * TC;
      else    m_pos = (m_pos + 1) % (TC * TR);
    end
    m_locked = m_acq && (m_streak >= LF);
    m_hs = hs;
    m_vs = vs;
    m_valid = 1;
    m_active = hs && vs && m_locked;
  endtask

  task automatic gen_drive();
    int line_end;
    hs_in = (gcol < AC) && !hold_line;
    vs_in = (grow < AR);
    line_end = short_line ? TC - 2 : TC - 1;
    if (gcol >= line_end) begin
      gcol = 0;
      grow = (grow + 1) % TR;
      if (storm) begin
        short_line = 1;
        hold_line = 0;
      end else if (rand_mode) begin
        short_line = ($urandom_range(0, 9) == 0);
        hold_line  = ($urandom_range(0, 9) == 0);
      end else begin
        short_line = inj_short;
        hold_line  = inj_hold;
        inj_short = 0;
        inj_hold = 0;
      end
    end else begin
      gcol++;
    end
  endtask

  // Called at a falling edge: check, drive the next pixel, advance the model, wait.
  task automatic cycle();
    check_outputs();
    gen_drive();
    if (rst_n) model_step(hs_in, vs_in);
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    run_cycles(2);
    rst_n = 1'b1;

    // Clean frames: lock after the third frame boundary.
    run_cycles(4 * TC * TR);
    check("locked_after_clean_frames", 32'(locked), 32'd1);

    // One shortened line while locked, then relock.
    inj_short = 1;
    run_cycles(4 * TC * TR);
    check("relocked_after_short_line", 32'(locked), 32'd1);

    // HSync held low for a whole line while locked.
    inj_hold = 1;
    run_cycles(4 * TC * TR);

    // Asynchronous reset mid-frame, then reacquire.
    n = 0;
    while (!(gcol == 5 && grow == 2) && n < 200) begin
      cycle();
      n++;
    end
    check("reset_point_reached", 32'(n < 200), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    run_cycles(3);
    rst_n = 1'b1;
    run_cycles(5 * TC * TR);
    check("locked_after_reset", 32'(locked), 32'd1);

    // Randomly faulted lines.
    rand_mode = 1;
    run_cycles(40 * TC * TR);
    rand_mode = 0;

    // Error storm: every line short, enough errors to saturate the counter.
    storm = 1;
    run_cycles(330 * (TC - 1));
    storm = 0;
    run_cycles(5 * TC * TR);
    check("locked_after_storm", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
